// File: rtl/l1_tlb_pkg.sv
// Shared types and constants for the L1 TLB refill controller.
package l1_tlb_pkg;

   localparam int unsigned VPN_W_DEF = 20;
   localparam int unsigned PPN_W_DEF = 20;
   localparam int unsigned TMO_W_DEF = 8;
   localparam int unsigned CMD_W     = 2;

   localparam logic [CMD_W-1:0] CMD_LOAD  = CMD_W'(0);
   localparam logic [CMD_W-1:0] CMD_STORE = CMD_W'(1);
   localparam logic [CMD_W-1:0] CMD_FETCH = CMD_W'(2);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_L2REQ  = 3'd1,
      ST_L2WAIT = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_CHECK  = 3'd4,
      ST_RESP   = 3'd5
   } state_e;

endpackage

// File: rtl/l1_tlb_refill_ctrl_fault_calc.sv
// Combinational access-fault equation from command, permissions and walk error.
module l1_tlb_fault_calc
   import l1_tlb_pkg::*;
(
   input  logic [CMD_W-1:0] cmd,
   input  logic             prot_r,
   input  logic             prot_w,
   input  logic             prot_x,
   input  logic             error,
   output logic             fault_c
);

   // Reserved command always faults.
   always_comb begin
      fault_c = 1'b1;
      case (cmd)
         CMD_LOAD:  fault_c = error | ~prot_r;
         CMD_STORE: fault_c = error | ~prot_w;
         CMD_FETCH: fault_c = error | ~prot_x;
         default:   fault_c = 1'b1;
      endcase
   end

endmodule

// File: rtl/l1_tlb_refill_ctrl.sv
// L1 TLB refill/passthrough front end feeding an external protection checker.
// Optional L2 response timeout: define L1_REFILL_TIMEOUT_EN.
module l1_tlb_refill_ctrl
   import l1_tlb_pkg::*;
#(
   parameter int unsigned VPN_W = VPN_W_DEF,
   parameter int unsigned PPN_W = PPN_W_DEF,
   parameter int unsigned TMO_W = TMO_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             io_req_valid,
   output logic             io_req_ready,
   input  logic [VPN_W-1:0] io_req_bits_vpn,
   input  logic [CMD_W-1:0] io_req_bits_cmd,
   input  logic             io_req_bits_passthrough,
   input  logic             io_kill,
   output logic             io_l2tlb_req_valid,
   input  logic             io_l2tlb_req_ready,
   output logic [VPN_W-1:0] io_l2tlb_req_bits_vpn,
   input  logic             io_l2tlb_resp_in_valid,
   input  logic [PPN_W-1:0] io_l2tlb_resp_in_ppn,
   input  logic             io_l2tlb_resp_in_error,
   output logic [VPN_W-1:0] chk_vpn,
   output logic             chk_refill_valid,
   output logic [PPN_W-1:0] chk_refill_ppn,
   input  logic             chk_prot_r,
   input  logic             chk_prot_w,
   input  logic             chk_prot_x,
   input  logic             chk_cacheable,
   input  logic [PPN_W-1:0] chk_ppn,
   output logic             io_resp_valid,
   input  logic             io_resp_ready,
   output logic [PPN_W-1:0] io_resp_bits_ppn,
   output logic             io_resp_bits_fault,
   output logic             io_resp_bits_cacheable
);

   if (TMO_W == 0) begin : g_tmo_w_chk
      $error("TMO_W must be nonzero");
   end

   state_e           state_q, state_n;
   logic             accept_c, take_l2_c, do_check_c, tmo_err_c, tmo_done_c;
   logic             fault_c;

   logic [VPN_W-1:0] vpn_q;
   logic [CMD_W-1:0] cmd_q;
   logic [PPN_W-1:0] l2_ppn_q;
   logic             err_q;
   logic             refill_valid_q;
   logic [PPN_W-1:0] resp_ppn_q;
   logic             resp_fault_q;
   logic             resp_cach_q;
   logic             req_ready_q;
   logic             l2_req_valid_q;
   logic             resp_valid_q;

   always_ff @(posedge clk) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_n;
   end

   // Next state plus one-cycle strobes for the datapath registers.
   always_comb begin
      state_n    = state_q;
      accept_c   = 1'b0;
      take_l2_c  = 1'b0;
      do_check_c = 1'b0;
      tmo_err_c  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (io_req_valid) begin
               accept_c = 1'b1;
               state_n  = io_req_bits_passthrough ? ST_CHECK : ST_L2REQ;
            end
         end
         ST_L2REQ: begin
            // A kill coinciding with the handshake still owes us a response.
            if (io_l2tlb_req_ready) state_n = io_kill ? ST_DRAIN : ST_L2WAIT;
            else if (io_kill)       state_n = ST_IDLE;
         end
         ST_L2WAIT: begin
            if (io_l2tlb_resp_in_valid) begin
               if (io_kill) state_n = ST_IDLE;
               else begin
                  take_l2_c = 1'b1;
                  state_n   = ST_CHECK;
               end
            end else if (io_kill) begin
               state_n = ST_DRAIN;
            end else if (tmo_done_c) begin
               tmo_err_c = 1'b1;
               state_n   = ST_CHECK;
            end
         end
         ST_DRAIN: begin
            if (io_l2tlb_resp_in_valid || tmo_done_c) state_n = ST_IDLE;
         end
         ST_CHECK: begin
            do_check_c = 1'b1;
            state_n    = io_kill ? ST_IDLE : ST_RESP;
         end
         ST_RESP: begin
            if (io_resp_ready) state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

`ifdef L1_REFILL_TIMEOUT_EN
   logic [TMO_W-1:0] tmo_q;

   // Cleared on every state change, so it restarts on entry to L2WAIT/DRAIN.
   always_ff @(posedge clk) begin
      if (!reset)                                          tmo_q <= '0;
      else if (state_n != state_q)                         tmo_q <= '0;
      else if (state_q == ST_L2WAIT || state_q == ST_DRAIN) tmo_q <= tmo_q + TMO_W'(1);
   end

   assign tmo_done_c = (state_q == ST_L2WAIT || state_q == ST_DRAIN) && (tmo_q == '1);
`else
   assign tmo_done_c = 1'b0;
`endif

   l1_tlb_fault_calc u_fault_calc (
      .cmd     (cmd_q),
      .prot_r  (chk_prot_r),
      .prot_w  (chk_prot_w),
      .prot_x  (chk_prot_x),
      .error   (err_q),
      .fault_c (fault_c)
   );

   // Datapath and registered handshake outputs decoded from the next state.
   always_ff @(posedge clk) begin
      if (!reset) begin
         vpn_q          <= '0;
         cmd_q          <= '0;
         l2_ppn_q       <= '0;
         err_q          <= 1'b0;
         refill_valid_q <= 1'b0;
         resp_ppn_q     <= '0;
         resp_fault_q   <= 1'b0;
         resp_cach_q    <= 1'b0;
         req_ready_q    <= 1'b1;
         l2_req_valid_q <= 1'b0;
         resp_valid_q   <= 1'b0;
      end else begin
         req_ready_q    <= (state_n == ST_IDLE);
         l2_req_valid_q <= (state_n == ST_L2REQ);
         resp_valid_q   <= (state_n == ST_RESP);
         if (accept_c) begin
            vpn_q          <= io_req_bits_vpn;
            cmd_q          <= io_req_bits_cmd;
            err_q          <= 1'b0;
            refill_valid_q <= 1'b0;
         end
         if (take_l2_c) begin
            l2_ppn_q       <= io_l2tlb_resp_in_ppn;
            err_q          <= io_l2tlb_resp_in_error;
            refill_valid_q <= 1'b1;
         end
         if (tmo_err_c) err_q <= 1'b1;
         if (do_check_c) begin
            resp_ppn_q   <= chk_ppn;
            resp_fault_q <= fault_c;
            resp_cach_q  <= chk_cacheable;
         end
      end
   end

   assign io_req_ready           = req_ready_q;
   assign io_l2tlb_req_valid     = l2_req_valid_q;
   assign io_l2tlb_req_bits_vpn  = vpn_q;
   assign chk_vpn                = vpn_q;
   assign chk_refill_valid       = refill_valid_q;
   assign chk_refill_ppn         = l2_ppn_q;
   assign io_resp_valid          = resp_valid_q;
   assign io_resp_bits_ppn       = resp_ppn_q;
   assign io_resp_bits_fault     = resp_fault_q;
   assign io_resp_bits_cacheable = resp_cach_q;

endmodule

// File: tb/tb_l1_tlb_refill_ctrl.sv
// Self-checking bench for l1_tlb_refill_ctrl with a transaction-level response model.
module tb_l1_tlb_refill_ctrl;

   localparam int unsigned VPN_W = 20;
   localparam int unsigned PPN_W = 20;
   localparam int unsigned TMO_W = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             io_req_valid, io_req_ready;
   logic [VPN_W-1:0] io_req_bits_vpn;
   logic [1:0]       io_req_bits_cmd;
   logic             io_req_bits_passthrough, io_kill;
   logic             io_l2tlb_req_valid, io_l2tlb_req_ready;
   logic [VPN_W-1:0] io_l2tlb_req_bits_vpn;
   logic             io_l2tlb_resp_in_valid, io_l2tlb_resp_in_error;
   logic [PPN_W-1:0] io_l2tlb_resp_in_ppn;
   logic [VPN_W-1:0] chk_vpn;
   logic             chk_refill_valid;
   logic [PPN_W-1:0] chk_refill_ppn, chk_ppn;
   logic             chk_prot_r, chk_prot_w, chk_prot_x, chk_cacheable;
   logic             io_resp_valid, io_resp_ready;
   logic [PPN_W-1:0] io_resp_bits_ppn;
   logic             io_resp_bits_fault, io_resp_bits_cacheable;

   logic perm_r, perm_w, perm_x, perm_c;

   l1_tlb_refill_ctrl #(.VPN_W(VPN_W), .PPN_W(PPN_W), .TMO_W(TMO_W)) dut (
      .clk(clk), .reset(reset),
      .io_req_valid(io_req_valid), .io_req_ready(io_req_ready),
      .io_req_bits_vpn(io_req_bits_vpn), .io_req_bits_cmd(io_req_bits_cmd),
      .io_req_bits_passthrough(io_req_bits_passthrough), .io_kill(io_kill),
      .io_l2tlb_req_valid(io_l2tlb_req_valid), .io_l2tlb_req_ready(io_l2tlb_req_ready),
      .io_l2tlb_req_bits_vpn(io_l2tlb_req_bits_vpn),
      .io_l2tlb_resp_in_valid(io_l2tlb_resp_in_valid), .io_l2tlb_resp_in_ppn(io_l2tlb_resp_in_ppn),
      .io_l2tlb_resp_in_error(io_l2tlb_resp_in_error),
      .chk_vpn(chk_vpn), .chk_refill_valid(chk_refill_valid), .chk_refill_ppn(chk_refill_ppn),
      .chk_prot_r(chk_prot_r), .chk_prot_w(chk_prot_w), .chk_prot_x(chk_prot_x),
      .chk_cacheable(chk_cacheable), .chk_ppn(chk_ppn),
      .io_resp_valid(io_resp_valid), .io_resp_ready(io_resp_ready),
      .io_resp_bits_ppn(io_resp_bits_ppn), .io_resp_bits_fault(io_resp_bits_fault),
      .io_resp_bits_cacheable(io_resp_bits_cacheable)
   );

   always #5 clk = ~clk;

   // Stand-in for the external checker: refill PPN when selected, else identity.
   assign chk_ppn       = chk_refill_valid ? chk_refill_ppn : chk_vpn;
   assign chk_prot_r    = perm_r;
   assign chk_prot_w    = perm_w;
   assign chk_prot_x    = perm_x;
   assign chk_cacheable = perm_c;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int resp_hs = 0, l2_hs = 0, l2_stall = 0, l2_vcyc = 0;

   bit               cmp_en = 1'b0;
   bit               exp_pending = 1'b0;
   int               exp_at = 0;
   logic [PPN_W-1:0] exp_ppn = '0;
   logic             exp_fault = 1'b0, exp_cach = 1'b0;
   logic [VPN_W-1:0] cur_vpn = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic fault_of(input logic [1:0] cmd, input logic r, w, x, err);
      if (err || cmd == 2'd3) return 1'b1;
      if (cmd == 2'd0) return !r;
      if (cmd == 2'd1) return !w;
      return !x;
   endfunction

   // Handshake and stall counters sampled on the active edge.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (reset && io_resp_valid && io_resp_ready) resp_hs <= resp_hs + 1;
      if (reset && io_l2tlb_req_valid && io_l2tlb_req_ready) l2_hs <= l2_hs + 1;
      if (reset && io_l2tlb_req_valid && !io_l2tlb_req_ready) l2_stall <= l2_stall + 1;
      if (io_l2tlb_req_valid) l2_vcyc <= l2_vcyc + 1;
   end

   // Per-cycle comparison of the response channel and the L2 request VPN.
   always @(negedge clk) begin
      if (cmp_en) begin
         logic exp_v;
         exp_v = exp_pending && (cyc >= exp_at);
         check("resp_valid", 32'(io_resp_valid), 32'(exp_v));
         if (exp_v && io_resp_valid) begin
            check("resp_ppn", 32'(io_resp_bits_ppn), 32'(exp_ppn));
            check("resp_fault", 32'(io_resp_bits_fault), 32'(exp_fault));
            check("resp_cacheable", 32'(io_resp_bits_cacheable), 32'(exp_cach));
         end
         if (io_l2tlb_req_valid)
            check("l2_req_vpn", 32'(io_l2tlb_req_bits_vpn), 32'(cur_vpn));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [VPN_W-1:0] vpn, input logic [1:0] cmd, input logic pt,
                        output int hs);
      check("req_ready_at_issue", 32'(io_req_ready), 32'd1);
      io_req_valid = 1'b1;
      io_req_bits_vpn = vpn;
      io_req_bits_cmd = cmd;
      io_req_bits_passthrough = pt;
      cur_vpn = vpn;
      hs = cyc;
      step();
      io_req_valid = 1'b0;
   endtask

   task automatic expect_resp(input int t0, input int lat, input logic [PPN_W-1:0] ppn,
                              input logic fault, input logic cach);
      exp_pending = 1'b1;
      exp_at = t0 + lat;
      exp_ppn = ppn;
      exp_fault = fault;
      exp_cach = cach;
   endtask

   task automatic wait_resp(input int budget);
      int  start;
      bit  got;
      start = resp_hs;
      got = 1'b0;
      for (int i = 0; i < budget && !got; i++) begin
         step();
         if (resp_hs != start) got = 1'b1;
      end
      check("resp_handshake_seen", 32'(got), 32'd1);
      exp_pending = 1'b0;
   endtask

   task automatic l2_resp(input logic [PPN_W-1:0] ppn, input logic err);
      io_l2tlb_resp_in_valid = 1'b1;
      io_l2tlb_resp_in_ppn = ppn;
      io_l2tlb_resp_in_error = err;
      step();
      io_l2tlb_resp_in_valid = 1'b0;
      io_l2tlb_resp_in_error = 1'b0;
   endtask

   logic [4:0] tbl [7] = '{5'b00011, 5'b01110, 5'b10110, 5'b11111, 5'b00100, 5'b10001, 5'b01101};

   initial begin
      int hs, base, t;
      reset = 1'b0;
      io_req_valid = 1'b0; io_req_bits_vpn = '0; io_req_bits_cmd = '0;
      io_req_bits_passthrough = 1'b0; io_kill = 1'b0;
      io_l2tlb_req_ready = 1'b1; io_l2tlb_resp_in_valid = 1'b0;
      io_l2tlb_resp_in_ppn = '0; io_l2tlb_resp_in_error = 1'b0;
      io_resp_ready = 1'b1;
      {perm_r, perm_w, perm_x, perm_c} = 4'b1111;

      repeat (3) step();
      check("rst_req_ready", 32'(io_req_ready), 32'd1);
      check("rst_resp_valid", 32'(io_resp_valid), 32'd0);
      check("rst_l2_req_valid", 32'(io_l2tlb_req_valid), 32'd0);
      check("rst_chk_vpn", 32'(chk_vpn), 32'd0);
      check("rst_chk_refill_valid", 32'(chk_refill_valid), 32'd0);
      check("rst_chk_refill_ppn", 32'(chk_refill_ppn), 32'd0);
      check("rst_resp_bits", {io_resp_bits_ppn, io_resp_bits_fault, io_resp_bits_cacheable}, 32'd0);
      reset = 1'b1;
      step();
      cmp_en = 1'b1;

      // Passthrough load: two-cycle latency, no L2 traffic.
      base = l2_vcyc;
      issue(20'h80000, 2'd0, 1'b1, hs);
      expect_resp(hs, 2, 20'h80000, 1'b0, 1'b1);
      wait_resp(10);
      check("pt_no_l2_req", 32'(l2_vcyc - base), 32'd0);

      // Refill store to a read-only page, L2 answers 5 cycles after the request.
      {perm_r, perm_w, perm_x, perm_c} = 4'b1010;
      base = l2_hs;
      issue(20'h12345, 2'd1, 1'b0, hs);
      expect_resp(hs, 7, 20'h00001, 1'b1, 1'b0);
      repeat (4) step();
      l2_resp(20'h00001, 1'b0);
      check("refill_chk_valid", 32'(chk_refill_valid), 32'd1);
      check("refill_chk_ppn", 32'(chk_refill_ppn), 32'h1);
      wait_resp(10);
      check("refill_l2_handshakes", 32'(l2_hs - base), 32'd1);

      // L2 request backpressure for four cycles.
      {perm_r, perm_w, perm_x, perm_c} = 4'b0011;
      io_l2tlb_req_ready = 1'b0;
      base = l2_hs;
      t = l2_stall;
      issue(20'h0ABCD, 2'd2, 1'b0, hs);
      repeat (4) step();
      io_l2tlb_req_ready = 1'b1;
      step();
      expect_resp(hs, 8, 20'h00ABC, 1'b0, 1'b1);
      l2_resp(20'h00ABC, 1'b0);
      wait_resp(10);
      check("bp_stall_cycles", 32'(l2_stall - t), 32'd4);
      check("bp_l2_handshakes", 32'(l2_hs - base), 32'd1);

      // Walk error with full permissions still faults.
      {perm_r, perm_w, perm_x, perm_c} = 4'b1111;
      issue(20'h55555, 2'd0, 1'b0, hs);
      expect_resp(hs, 4, 20'h0F0F0, 1'b1, 1'b1);
      step();
      l2_resp(20'h0F0F0, 1'b1);
      wait_resp(10);

      // Permission/command table through the passthrough path.
      for (int i = 0; i < 7; i++) begin
         logic [4:0]       v;
         logic [VPN_W-1:0] vpn;
         v = tbl[i];
         {perm_r, perm_w, perm_x} = v[2:0];
         perm_c = i[0];
         vpn = 20'(256 + i * 4369);
         issue(vpn, v[4:3], 1'b1, hs);
         expect_resp(hs, 2, vpn, fault_of(v[4:3], v[2], v[1], v[0], 1'b0), perm_c);
         wait_resp(10);
      end

      // Kill before the L2 handshake: nothing issued.
      io_l2tlb_req_ready = 1'b0;
      base = l2_hs;
      issue(20'h66666, 2'd0, 1'b0, hs);
      io_kill = 1'b1;
      step();
      io_kill = 1'b0;
      io_l2tlb_req_ready = 1'b1;
      check("kill_l2req_idle", 32'(io_req_ready), 32'd1);
      step();
      check("kill_l2req_no_issue", 32'(l2_hs - base), 32'd0);

      // Kill in L2WAIT drains the late response.
      issue(20'h11111, 2'd0, 1'b0, hs);
      step();
      io_kill = 1'b1;
      step();
      io_kill = 1'b0;
      check("drain_busy", 32'(io_req_ready), 32'd0);
      io_kill = 1'b1;
      step();
      io_kill = 1'b0;
      check("drain_ignores_kill", 32'(io_req_ready), 32'd0);
      l2_resp(20'h0DEAD, 1'b0);
      check("drain_to_idle", 32'(io_req_ready), 32'd1);
      check("drain_drops_resp", 32'(chk_refill_valid), 32'd0);

      // Kill together with the response goes straight to idle.
      issue(20'h22222, 2'd0, 1'b0, hs);
      step();
      io_kill = 1'b1;
      io_l2tlb_resp_in_valid = 1'b1;
      io_l2tlb_resp_in_ppn = 20'h0BAD0;
      step();
      io_kill = 1'b0;
      io_l2tlb_resp_in_valid = 1'b0;
      check("kill_resp_idle", 32'(io_req_ready), 32'd1);
      check("kill_resp_discard", 32'(chk_refill_valid), 32'd0);

      // Kill in CHECK: no response.
      issue(20'h77777, 2'd0, 1'b1, hs);
      io_kill = 1'b1;
      step();
      io_kill = 1'b0;
      check("kill_check_idle", 32'(io_req_ready), 32'd1);

      // Held response ignores kill, then reset clears it.
      {perm_r, perm_w, perm_x, perm_c} = 4'b1101;
      io_resp_ready = 1'b0;
      issue(20'h33333, 2'd2, 1'b1, hs);
      expect_resp(hs, 2, 20'h33333, 1'b1, 1'b1);
      step();
      io_kill = 1'b1;
      step();
      io_kill = 1'b0;
      repeat (2) step();
      check("resp_held_valid", 32'(io_resp_valid), 32'd1);
      cmp_en = 1'b0;
      exp_pending = 1'b0;
      reset = 1'b0;
      step();
      reset = 1'b1;
      check("post_rst_resp_valid", 32'(io_resp_valid), 32'd0);
      check("post_rst_req_ready", 32'(io_req_ready), 32'd1);
      check("post_rst_chk_vpn", 32'(chk_vpn), 32'd0);
      io_resp_ready = 1'b1;
      cmp_en = 1'b1;

      // Stray L2 response in idle is ignored.
      l2_resp(20'h0BEEF, 1'b0);
      check("idle_ignores_resp_ready", 32'(io_req_ready), 32'd1);
      check("idle_ignores_resp_valid", 32'(chk_refill_valid), 32'd0);
      check("idle_ignores_resp_ppn", 32'(chk_refill_ppn), 32'd0);

      {perm_r, perm_w, perm_x, perm_c} = 4'b1000;
`ifdef L1_REFILL_TIMEOUT_EN
      // No L2 response: timeout after 15 cycles in L2WAIT, then CHECK and RESP.
      issue(20'h44444, 2'd0, 1'b0, hs);
      expect_resp(hs, 19, 20'h44444, 1'b1, 1'b0);
      wait_resp(30);
`else
      // Without the timeout the controller keeps waiting for L2.
      issue(20'h44444, 2'd0, 1'b0, hs);
      repeat (30) step();
      check("no_timeout_busy", 32'(io_req_ready), 32'd0);
      t = cyc;
      expect_resp(t, 2, 20'h0CAFE, 1'b0, 1'b0);
      l2_resp(20'h0CAFE, 1'b0);
      wait_resp(10);
`endif

      step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1);
   end

endmodule

// File: doc/l1_tlb_refill_ctrl.md
Name: l1_tlb_refill_ctrl

Overview:
- Sequential front end of the L1 address/protection checker.
- Accepts one translation request from the core and either passes the VPN through (translation off) or fetches a PTE from the L2 TLB.
- Drives the refill/passthrough select and PPN into the combinational protection checker, samples its r/w/x/cacheable result, and returns a registered response with an access-fault flag.
- Handles one request at a time (blocking).

Parameters:
- VPN_W, 20, virtual page number width
- PPN_W, 20, physical page number width
- TMO_W, 8, width of the L2 response timeout counter (used only with the optional feature)

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-low reset; state is reset on a rising clk edge while reset==0
- io_req_valid  input  1  core translation request valid
- io_req_ready  output  1  block can accept a request (IDLE only)
- io_req_bits_vpn  input  VPN_W  virtual page number
- io_req_bits_cmd  input  2  0=load, 1=store, 2=fetch, 3=reserved
- io_req_bits_passthrough  input  1  translation disabled; PPN = VPN
- io_kill  input  1  abort the in-flight request
- io_l2tlb_req_valid  output  1  L2 TLB lookup request
- io_l2tlb_req_ready  input  1  L2 TLB accepts the request
- io_l2tlb_req_bits_vpn  output  VPN_W  VPN sent to the L2 TLB
- io_l2tlb_resp_in_valid  input  1  L2 TLB response strobe (one cycle)
- io_l2tlb_resp_in_ppn  input  PPN_W  PTE PPN returned by the L2 TLB
- io_l2tlb_resp_in_error  input  1  page fault or walk error from the L2 TLB
- chk_vpn  output  VPN_W  to checker: io_req_bits_vpn
- chk_refill_valid  output  1  to checker: io_l2tlb_resp_valid (select the refill PPN)
- chk_refill_ppn  output  PPN_W  to checker: io_l2tlb_resp_bits_pte_ppn
- chk_prot_r / chk_prot_w / chk_prot_x  input  1 each  checker permission result
- chk_cacheable  input  1  checker cacheable result
- chk_ppn  input  PPN_W  PPN selected by the checker
- io_resp_valid  output  1  translation response valid
- io_resp_ready  input  1  core consumes the response
- io_resp_bits_ppn  output  PPN_W  translated PPN
- io_resp_bits_fault  output  1  access fault
- io_resp_bits_cacheable  output  1  cacheable attribute

Behaviour:
- States: IDLE, L2REQ, L2WAIT, DRAIN, CHECK, RESP. Reset state is IDLE.
- Reset values: all outputs 0, except io_req_ready=1 (IDLE). The VPN, PPN and error registers reset to 0.
- IDLE:
  - io_req_ready=1.
  - On io_req_valid, latch vpn, cmd and passthrough.
  - passthrough=1 goes to CHECK with refill_valid=0; otherwise go to L2REQ.
- L2REQ:
  - io_l2tlb_req_valid=1, with the VPN held stable until io_l2tlb_req_ready.
  - On the handshake go to L2WAIT.
  - io_kill before the handshake goes to IDLE and nothing is issued.
- L2WAIT:
  - On io_l2tlb_resp_in_valid, latch ppn and error, set refill_valid=1, and go to CHECK.
  - io_kill without a response goes to DRAIN.
  - io_kill in the same cycle as the response goes to IDLE and discards the response.
- DRAIN:
  - Wait for io_l2tlb_resp_in_valid, discard it, then go to IDLE. io_kill is ignored here.
  - A response arriving in any state other than L2WAIT or DRAIN is ignored.
- chk_* outputs are driven from the registers in every state, so the checker input is stable for the whole of CHECK.
- CHECK:
  - One cycle. Register ppn=chk_ppn and cacheable=chk_cacheable.
  - fault = error OR (cmd==0 & !r) OR (cmd==1 & !w) OR (cmd==2 & !x) OR (cmd==3).
  - Go to RESP. io_kill in CHECK goes to IDLE with no response.
- RESP:
  - io_resp_valid=1; bits held until io_resp_ready, then go to IDLE.
  - io_kill is ignored once in RESP.
  - A new request is accepted no earlier than the cycle after the response handshake.
- Latency, counted from the request handshake to io_resp_valid:
  - passthrough: 2 cycles;
  - refill: L2 latency + 2 cycles.
- Reset while the FSM is in any state returns it to IDLE; any outstanding L2 response that arrives later is ignored in IDLE.

Optional Feature:
- Macro: L1_REFILL_TIMEOUT_EN.
- When defined:
  - a TMO_W-bit counter clears on entry to L2WAIT/DRAIN and increments each cycle in those states;
  - at all-ones in L2WAIT, go to CHECK with error=1, so the response carries fault=1 and ppn=chk_ppn;
  - at all-ones in DRAIN, go to IDLE.
- When undefined: no counter; the FSM waits indefinitely.

Decomposition:
- Shared package l1_tlb_pkg holds:
  - the state encoding enum;
  - cmd constants CMD_LOAD=0, CMD_STORE=1, CMD_FETCH=2;
  - default VPN_W/PPN_W.
- Natural sub-module: l1_tlb_fault_calc, the combinational fault equation from cmd, r/w/x and error.
- The protection checker stays external and is connected at the chk_* ports.

Test Plan:
- Passthrough:
  - Stimulus: vpn=0x80000, cmd=load, passthrough=1; checker gives r=w=x=1, cacheable=1.
  - Required: resp after 2 cycles with ppn=0x80000, fault=0, cacheable=1; io_l2tlb_req_valid never set.
- Refill store to a read-only page:
  - Stimulus: L2 returns ppn=0x00001 after 5 cycles; checker gives r=1, w=0, x=1.
  - Required: chk_refill_valid=1 in CHECK; resp fault=1, ppn=0x00001, at 7 cycles.
- L2 backpressure:
  - Stimulus: io_l2tlb_req_ready low for 4 cycles.
  - Required: req_valid and vpn held stable for 4 cycles; a single handshake.
- Kill cases:
  - Stimulus: kill in L2WAIT.
  - Required: FSM goes to DRAIN; the next response is dropped; IDLE; io_resp_valid stays 0.
  - Stimulus: kill in the same cycle as the response.
  - Required: direct to IDLE.
- Response backpressure then reset:
  - Stimulus: io_resp_ready=0 for 3 cycles, then reset=0 for 1 cycle.
  - Required: resp bits stable while held; after reset, resp_valid=0 and req_ready=1.
- With L1_REFILL_TIMEOUT_EN, TMO_W=4:
  - Stimulus: no L2 response.
  - Required: resp with fault=1, 15 cycles after L2WAIT entry plus 2.
